// File: rtl/fir_feeder_pkg.sv
// fir_feeder shared definitions: default sizes,
// run-state encoding and a counter-width helper.
package fir_feeder_pkg;

   localparam int NTAPS_DEF      = 64;
   localparam int DW_DEF         = 16;
   localparam int AW_DEF         = 14;
   localparam int TICK_DIV_DEF   = 1000;
   localparam int FIFO_DEPTH_DEF = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      STREAM = 2'd2,
      DONE   = 2'd3
   } state_t;

   // Bits needed to hold values 0..n-1 (at least 1).
   function automatic int ctr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fir_feeder_sync_fifo.sv
// Sample buffer for fir_feeder: DEPTH-entry synchronous FIFO.
// Ports: clk, rst_n (async low), push/din, pop/dout (show-ahead),
// full, empty. Push when full and pop when empty are ignored.
module fir_feeder_sync_fifo #(
   parameter int DW         = 16,
   parameter int FIFO_DEPTH = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [DW-1:0] din,
   input  logic          pop,
   output logic [DW-1:0] dout,
   output logic          full,
   output logic          empty
);

   localparam int PW = $clog2(FIFO_DEPTH);

   logic [DW-1:0] r_mem [FIFO_DEPTH];
   logic [PW:0]   r_wr;
   logic [PW:0]   r_rd;
   logic          w_do_push;
   logic          w_do_pop;

   // Extra pointer bit tells full from empty when indices match.
   assign empty = (r_wr == r_rd);
   assign full  = (r_wr[PW] != r_rd[PW]) &&
                  (r_wr[PW-1:0] == r_rd[PW-1:0]);

   assign w_do_push = push && !full;
   assign w_do_pop  = pop && !empty;
   assign dout      = r_mem[r_rd[PW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr <= '0;
         r_rd <= '0;
      end else begin
         if (w_do_push) r_wr <= r_wr + 1'b1;
         if (w_do_pop)  r_rd <= r_rd + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr[PW-1:0]] <= din;
   end

endmodule

// File: rtl/fir_feeder.sv
// fir_feeder: loads NTAPS coefficients into the FIR, then paces
// buffered host samples out at one per TICK_DIV core cycles.
// Ports: clk2/rstn; start, n_samples (run control);
// s_valid/s_data/s_ready (host stream); w_en/addr/data_in/valid_in
// (FIR side); busy, coef_done, underrun, done (status).
module fir_feeder
   import fir_feeder_pkg::*;
#(
   parameter int NTAPS      = NTAPS_DEF,
   parameter int DW         = DW_DEF,
   parameter int AW         = AW_DEF,
   parameter int TICK_DIV   = TICK_DIV_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic          clk2,
   input  logic          rstn,
   input  logic          start,
   input  logic [15:0]   n_samples,
   input  logic          s_valid,
   input  logic [DW-1:0] s_data,
   output logic          s_ready,
   output logic          w_en,
   output logic [AW-1:0] addr,
   output logic [DW-1:0] data_in,
   output logic          valid_in,
   output logic          busy,
   output logic          coef_done,
   output logic          underrun,
   output logic          done
);

   localparam int CW = ctr_w(NTAPS + 1);
   localparam int TW = ctr_w(TICK_DIV);

   localparam logic [CW-1:0] N_COEF    = CW'(NTAPS);
   localparam logic [CW-1:0] LAST_COEF = CW'(NTAPS - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

   state_t        r_state;
   state_t        w_next;

   logic [CW-1:0] r_ncoef;
   logic [15:0]   r_nsamp;
   logic [15:0]   r_acc;
   logic [15:0]   r_sent;
   logic [TW-1:0] r_tick;

   logic          r_w_en;
   logic          r_valid;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_data;
   logic          r_coef_done;
   logic          r_underrun;

   logic          w_ready;
   logic          w_load_hs;
   logic          w_push;
   logic          w_active;
   logic          w_slot;
   logic          w_pop;
   logic          w_full;
   logic          w_empty;
   logic [DW-1:0] w_dout;

   // ---------------- state register ----------------
   always_ff @(posedge clk2 or negedge rstn) begin
      if (!rstn) r_state <= IDLE;
      else       r_state <= w_next;
   end

   // ------------- next state / s_ready -------------
   // LOAD stays one extra cycle with s_ready low once all
   // coefficients are in, so no sample word is taken early.
   always_comb begin
      w_next  = r_state;
      w_ready = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (start) w_next = LOAD;
         end
         LOAD: begin
            w_ready = (r_ncoef != N_COEF);
            if (!w_ready)
               w_next = (r_nsamp == 16'd0) ? DONE : STREAM;
         end
         STREAM: begin
            w_ready = !w_full && (r_acc < r_nsamp);
            if (r_sent == r_nsamp) w_next = DONE;
         end
         DONE: begin
            w_next = IDLE;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   assign w_load_hs = (r_state == LOAD) && s_valid && w_ready;
   assign w_push    = (r_state == STREAM) && s_valid && w_ready;
   assign w_active  = (r_state == STREAM) && (r_sent != r_nsamp);
   assign w_slot    = w_active && (r_tick == TICK_LAST);
   // empty is registered, so a same-cycle push is not seen here.
   assign w_pop     = w_slot && !w_empty;

   // ---------------- datapath ----------------
   always_ff @(posedge clk2 or negedge rstn) begin
      if (!rstn) begin
         r_ncoef     <= '0;
         r_nsamp     <= '0;
         r_acc       <= '0;
         r_sent      <= '0;
         r_tick      <= '0;
         r_w_en      <= 1'b0;
         r_valid     <= 1'b0;
         r_addr      <= '0;
         r_data      <= '0;
         r_coef_done <= 1'b0;
         r_underrun  <= 1'b0;
      end else begin
         r_w_en  <= 1'b0;
         r_valid <= 1'b0;

         if ((r_state == IDLE) && start) begin
            r_nsamp     <= n_samples;
            r_ncoef     <= '0;
            r_acc       <= '0;
            r_sent      <= '0;
            r_tick      <= '0;
            r_coef_done <= 1'b0;
            r_underrun  <= 1'b0;
         end

         if (w_load_hs) begin
            r_w_en  <= 1'b1;
            r_addr  <= AW'(r_ncoef);
            r_data  <= s_data;
            r_ncoef <= r_ncoef + 1'b1;
            if (r_ncoef == LAST_COEF) r_coef_done <= 1'b1;
         end

         if (w_push) r_acc <= r_acc + 16'd1;

         if (w_active) begin
            if (r_tick == TICK_LAST) r_tick <= '0;
            else                     r_tick <= r_tick + 1'b1;
         end

         if (w_pop) begin
            r_valid <= 1'b1;
            r_data  <= w_dout;
            r_sent  <= r_sent + 16'd1;
         end

         if (w_slot && w_empty) r_underrun <= 1'b1;
      end
   end

   fir_feeder_sync_fifo #(
      .DW         (DW),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk2),
      .rst_n (rstn),
      .push  (w_push),
      .din   (s_data),
      .pop   (w_pop),
      .dout  (w_dout),
      .full  (w_full),
      .empty (w_empty)
   );

   assign s_ready   = w_ready;
   assign w_en      = r_w_en;
   assign addr      = r_addr;
   assign data_in   = r_data;
   assign valid_in  = r_valid;
   assign busy      = (r_state == LOAD) || (r_state == STREAM);
   assign coef_done = r_coef_done;
   assign underrun  = r_underrun;
   assign done      = (r_state == DONE);

endmodule

// File: tb/tb_fir_feeder.sv
// Bench for fir_feeder: directed runs with randomized data,
// checked cycle by cycle against a queue-based reference model.
module tb_fir_feeder;

   localparam int NT = 64;
   localparam int DW = 16;
   localparam int AW = 14;
   localparam int TD = 4;
   localparam int FD = 8;

   logic          clk2 = 1'b0;
   logic          rstn = 1'b1;
   logic          start = 1'b0;
   logic [15:0]   n_samples = '0;
   logic          s_valid = 1'b0;
   logic [DW-1:0] s_data = '0;
   logic          s_ready;
   logic          w_en;
   logic [AW-1:0] addr;
   logic [DW-1:0] data_in;
   logic          valid_in;
   logic          busy;
   logic          coef_done;
   logic          underrun;
   logic          done;

   always #5 clk2 = ~clk2;

   fir_feeder #(
      .NTAPS      (NT),
      .DW         (DW),
      .AW         (AW),
      .TICK_DIV   (TD),
      .FIFO_DEPTH (FD)
   ) dut (
      .clk2      (clk2),
      .rstn      (rstn),
      .start     (start),
      .n_samples (n_samples),
      .s_valid   (s_valid),
      .s_data    (s_data),
      .s_ready   (s_ready),
      .w_en      (w_en),
      .addr      (addr),
      .data_in   (data_in),
      .valid_in  (valid_in),
      .busy      (busy),
      .coef_done (coef_done),
      .underrun  (underrun),
      .done      (done)
   );

   int checks = 0;
   int failures = 0;

   // reference model: phase 0 idle, 1 load, 2 stream, 3 done
   int            m_phase, m_ncoef, m_acc, m_sent, m_tick, m_nsamp;
   logic [DW-1:0] q[$];
   logic          e_wen, e_valid, e_cd, e_ur;
   logic [AW-1:0] e_addr;
   logic [DW-1:0] e_data;

   // observation stats per run
   int            cyc, n_wen, n_val, n_done, n_hs;
   bit            saw_full, aborted;
   int            vt[$];
   logic [DW-1:0] vd[$];
   logic [DW-1:0] sbase;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic m_ready();
      if (m_phase == 1) return m_ncoef < NT;
      if (m_phase == 2) return (q.size() < FD) && (m_acc < m_nsamp);
      return 1'b0;
   endfunction

   task automatic model_reset();
      m_phase = 0; m_ncoef = 0; m_acc = 0; m_sent = 0;
      m_tick = 0; m_nsamp = 0; q.delete();
      e_wen = 0; e_valid = 0; e_cd = 0; e_ur = 0;
      e_addr = '0; e_data = '0;
   endtask

   task automatic chk_zero(input string p);
      chk({p, "s_ready"},   32'(s_ready),   0);
      chk({p, "w_en"},      32'(w_en),      0);
      chk({p, "addr"},      32'(addr),      0);
      chk({p, "data_in"},   32'(data_in),   0);
      chk({p, "valid_in"},  32'(valid_in),  0);
      chk({p, "busy"},      32'(busy),      0);
      chk({p, "coef_done"}, 32'(coef_done), 0);
      chk({p, "underrun"},  32'(underrun),  0);
      chk({p, "done"},      32'(done),      0);
   endtask

   // One clock: compare at negedge, advance model, return at posedge+1.
   task automatic cycle();
      logic hs, slot;
      @(negedge clk2);
      cyc++;
      chk("s_ready",   32'(s_ready),   32'(m_ready()));
      chk("w_en",      32'(w_en),      32'(e_wen));
      chk("addr",      32'(addr),      32'(e_addr));
      chk("data_in",   32'(data_in),   32'(e_data));
      chk("valid_in",  32'(valid_in),  32'(e_valid));
      chk("busy",      32'(busy),      32'(m_phase == 1 || m_phase == 2));
      chk("coef_done", 32'(coef_done), 32'(e_cd));
      chk("underrun",  32'(underrun),  32'(e_ur));
      chk("done",      32'(done),      32'(m_phase == 3));
      chk("wen_x_val", 32'(w_en & valid_in), 0);
      if (w_en) n_wen++;
      if (valid_in) begin
         n_val++; vt.push_back(cyc); vd.push_back(data_in);
      end
      if (done) n_done++;
      if (m_phase == 2 && s_valid && !s_ready && m_acc < m_nsamp)
         saw_full = 1;
      if (rstn) begin
         hs = s_valid && m_ready();
         e_wen = 0; e_valid = 0;
         case (m_phase)
            0: if (start) begin
               m_phase = 1; m_nsamp = int'(n_samples);
               m_ncoef = 0; m_acc = 0; m_sent = 0; m_tick = 0;
               e_cd = 0; e_ur = 0;
            end
            1: if (m_ncoef < NT) begin
               if (hs) begin
                  e_wen = 1; e_addr = AW'(m_ncoef); e_data = s_data;
                  m_ncoef++;
                  if (m_ncoef == NT) e_cd = 1;
               end
            end else begin
               m_phase = (m_nsamp == 0) ? 3 : 2;
               m_tick = 0;
            end
            2: if (m_sent == m_nsamp) m_phase = 3;
            else begin
               slot = (m_tick == TD - 1);
               if (slot) begin
                  if (q.size() > 0) begin
                     e_valid = 1; e_data = q.pop_front(); m_sent++;
                  end else e_ur = 1;
               end
               if (hs) begin
                  q.push_back(s_data); m_acc++; n_hs++;
               end
               m_tick = slot ? 0 : m_tick + 1;
            end
            default: m_phase = 0;
         endcase
      end
      @(posedge clk2); #1;
   endtask

   // smode: 0 host always valid, 1 late second sample, 2 random
   task automatic run(input int n, input int smode, input bit lrand,
                      input int inj, input int abort_q);
      int sc, k;
      n_wen = 0; n_val = 0; n_done = 0; n_hs = 0;
      saw_full = 0; aborted = 0; vt.delete(); vd.delete();
      s_valid = 0; n_samples = 16'(n); start = 1;
      cycle();
      start = 0; n_samples = 16'($urandom);
      sc = 0; k = 0;
      while (m_phase != 0 && k < 5000) begin
         start = 0; s_valid = 0; s_data = DW'($urandom);
         if (m_phase == 1) begin
            s_valid = lrand ? 1'($urandom_range(0, 1)) : 1'b1;
            s_data = 16'h1000 + 16'(m_ncoef);
         end else if (m_phase == 2) begin
            case (smode)
               0: s_valid = 1'b1;
               1: s_valid = (m_acc == 0) || (sc >= 12);
               default: s_valid = 1'($urandom_range(0, 1));
            endcase
            s_data = sbase + DW'(m_acc);
            if (sc == inj) begin start = 1; n_samples = 16'd3; end
            sc++;
         end
         cycle();
         k++;
         if (abort_q > 0 && m_phase == 2 && q.size() == abort_q) begin
            aborted = 1;
            break;
         end
      end
      start = 0; s_valid = 0;
      if (!aborted) chk("run_timeout", 32'(k < 5000), 1);
   endtask

   task automatic chk_samples(input int n);
      chk("n_valid", 32'(n_val), 32'(n));
      for (int i = 0; i < vd.size(); i++)
         chk("sample_data", 32'(vd[i]), 32'(sbase + DW'(i)));
   endtask

   initial begin
      model_reset();
      cyc = 0;
      #1 rstn = 0;
      repeat (2) cycle();
      rstn = 1;
      repeat (2) cycle();

      // coefficient load + paced stream of 0xA0..0xA4
      sbase = 16'h00A0;
      run(5, 0, 0, -1, 0);
      chk("A_n_wen", 32'(n_wen), NT);
      chk_samples(5);
      for (int i = 1; i < vt.size(); i++)
         chk("A_spacing", 32'(vt[i] - vt[i-1]), TD);
      chk("A_done_once", 32'(n_done), 1);
      chk("A_underrun", 32'(underrun), 0);
      chk("A_coef_done", 32'(coef_done), 1);

      // second sample arrives late: slots lost
      sbase = DW'($urandom);
      run(2, 1, 1, -1, 0);
      chk("B_n_wen", 32'(n_wen), NT);
      chk_samples(2);
      chk("B_underrun", 32'(underrun), 1);
      chk("B_done_once", 32'(n_done), 1);

      // backpressure, start pulse mid-stream ignored
      sbase = DW'($urandom);
      run(20, 0, 1, 6, 0);
      chk("C_accepted", 32'(n_hs), 20);
      chk_samples(20);
      chk("C_full_seen", 32'(saw_full), 1);
      chk("C_done_once", 32'(n_done), 1);

      // zero samples: LOAD straight to DONE
      run(0, 2, 1, -1, 0);
      chk("D_n_wen", 32'(n_wen), NT);
      chk("D_n_valid", 32'(n_val), 0);
      chk("D_done_once", 32'(n_done), 1);

      // reset while streaming with 3 words buffered
      sbase = DW'($urandom);
      run(10, 0, 0, -1, 3);
      chk("E_aborted", 32'(aborted), 1);
      rstn = 0;
      #1 chk_zero("E_rst_");
      model_reset();
      repeat (2) cycle();
      rstn = 1;
      s_valid = 1;
      repeat (3) cycle();
      s_valid = 0;

      // fresh run sees an empty FIFO
      sbase = DW'($urandom);
      run(2, 0, 1, -1, 0);
      chk_samples(2);
      chk("F_done_once", 32'(n_done), 1);
      chk("F_underrun", 32'(underrun), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
